// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: issues PC requests, buffers in-order responses with their PCs, flushes on redirect.
// Optional IF_FETCH_STAGE_PERF_EN adds a saturating decode-starvation counter on stall_cycles.
module if_fetch_stage #(
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc,
    input  logic        redirect,
    output logic        pc_advance,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] stall_cycles
);

    localparam int unsigned FP_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned PQ_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 2;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
    } fetch_entry_t;

    logic [CNT_W-1:0] r_outstanding;
    logic [CNT_W-1:0] r_discard;
    logic [CNT_W-1:0] r_fifo_count;
    logic [31:0]      r_pq [MAX_OUTSTANDING];
    logic [PQ_W-1:0]  r_pq_head;
    logic [PQ_W-1:0]  r_pq_tail;
    fetch_entry_t     r_fifo [FIFO_DEPTH];
    logic [FP_W-1:0]  r_wr_ptr;
    logic [FP_W-1:0]  r_rd_ptr;

    logic             w_req_valid;
    logic             w_accept;
    logic             w_rsp_live;
    logic             w_rsp_drop;
    logic             w_id_valid;
    logic             w_pop;
    logic [CNT_W-1:0] w_inflight;
    logic [CNT_W-1:0] w_discard_flush;

    function automatic logic [PQ_W-1:0] pq_inc(input logic [PQ_W-1:0] p);
        return (p == PQ_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PQ_W'(1);
    endfunction

    // Credit check: every live response is guaranteed a free FIFO slot.
    always_comb begin
        w_inflight      = r_outstanding + r_discard;
        w_req_valid     = rst_n && !redirect
                          && (w_inflight < CNT_W'(MAX_OUTSTANDING))
                          && ((r_outstanding + r_fifo_count) < CNT_W'(FIFO_DEPTH));
        w_accept        = w_req_valid && imem_req_ready;
        w_rsp_drop      = imem_rsp_valid && !redirect && (r_discard != '0);
        w_rsp_live      = imem_rsp_valid && !redirect && (r_discard == '0) && (r_outstanding != '0);
        w_id_valid      = (r_fifo_count != '0);
        w_pop           = w_id_valid && id_ready && !redirect;
        w_discard_flush = w_inflight - CNT_W'(imem_rsp_valid && (w_inflight != '0));
    end

    assign imem_req_valid = w_req_valid;
    assign pc_advance     = w_accept;
    assign imem_req_addr  = pc;
    assign id_valid       = w_id_valid;
    assign id_instr       = r_fifo[r_rd_ptr].instr;
    assign id_pc          = r_fifo[r_rd_ptr].addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outstanding <= '0;
            r_discard     <= '0;
            r_fifo_count  <= '0;
            r_pq_head     <= '0;
            r_pq_tail     <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) r_pq[i] <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= '0;
        end else if (redirect) begin
            // Everything in flight becomes stale; the coincident response is the first one dropped.
            r_outstanding <= '0;
            r_discard     <= w_discard_flush;
            r_fifo_count  <= '0;
            r_pq_head     <= '0;
            r_pq_tail     <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
        end else begin
            r_outstanding <= r_outstanding + CNT_W'(w_accept) - CNT_W'(w_rsp_live);
            r_fifo_count  <= r_fifo_count + CNT_W'(w_rsp_live) - CNT_W'(w_pop);
            if (w_rsp_drop) r_discard <= r_discard - CNT_W'(1);
            if (w_accept) begin
                r_pq[r_pq_tail] <= pc;
                r_pq_tail       <= pq_inc(r_pq_tail);
            end
            if (w_rsp_live) begin
                r_fifo[r_wr_ptr] <= '{addr: r_pq[r_pq_head], instr: imem_rsp_data};
                r_wr_ptr         <= r_wr_ptr + FP_W'(1);
                r_pq_head        <= pq_inc(r_pq_head);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + FP_W'(1);
        end
    end

`ifdef IF_FETCH_STAGE_PERF_EN
    logic [31:0] r_stall_cycles;

    // Saturating count of cycles where decode was ready but starved.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
        end else if (id_ready && !w_id_valid && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Testbench for if_fetch_stage: in-order memory with variable latency and a queue-based reference
// of the live fetch stream, driven by directed phases and randomized traffic.
module tb_if_fetch_stage;

    localparam int unsigned FIFO_DEPTH      = 4;
    localparam int unsigned MAX_OUTSTANDING = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc;
    logic        redirect;
    logic        pc_advance;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] stall_cycles;

    if_fetch_stage #(.FIFO_DEPTH(FIFO_DEPTH), .MAX_OUTSTANDING(MAX_OUTSTANDING)) dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .redirect(redirect), .pc_advance(pc_advance),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          lat = 1;
    int          last_due = -1;
    logic [31:0] pcv = 32'h0;
    logic        redir = 1'b0;
    logic [31:0] redir_target = 32'h0;
    logic        rdy = 1'b0;
    logic        idr = 1'b0;
    logic [31:0] stall_exp = 32'h0;

    // Memory in flight (oldest first) and the expected decode queue.
    logic [31:0] mem_addr [$];
    int          mem_due  [$];
    bit          mem_live [$];
    logic [31:0] mf_pc    [$];
    logic [31:0] mf_instr [$];

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s obs=%h exp=%h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
        check({tag, "_pc_advance"}, 32'(pc_advance), 32'd0);
        check({tag, "_id_valid"}, 32'(id_valid), 32'd0);
        check({tag, "_id_instr"}, id_instr, 32'd0);
        check({tag, "_id_pc"}, id_pc, 32'd0);
        check({tag, "_stall"}, stall_cycles, 32'd0);
    endtask

    task automatic model_reset(input logic [31:0] start_pc);
        mem_addr.delete(); mem_due.delete(); mem_live.delete();
        mf_pc.delete(); mf_instr.delete();
        last_due  = -1;
        stall_exp = 32'h0;
        pcv       = start_pc;
    endtask

    // One clock cycle: drive at posedge+1, check at negedge, update the reference at the next posedge.
    task automatic do_cycle();
        int  o, d, due;
        bit  exp_rv, exp_adv, exp_idv, rsp_push;
        logic [31:0] rsp_addr;
        imem_rsp_valid = (mem_due.size() != 0) && (mem_due[0] == cyc);
        imem_rsp_data  = imem_rsp_valid ? instr_of(mem_addr[0]) : $urandom;
        pc             = pcv;
        redirect       = redir;
        imem_req_ready = rdy;
        id_ready       = idr;
        @(negedge clk);
        o = 0; d = 0;
        foreach (mem_live[i]) if (mem_live[i]) o++; else d++;
        exp_rv  = !redir && (o + d < int'(MAX_OUTSTANDING)) && (o + mf_pc.size() < int'(FIFO_DEPTH));
        exp_adv = exp_rv && rdy;
        exp_idv = (mf_pc.size() != 0);
        check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        check("pc_advance", 32'(pc_advance), 32'(exp_adv));
        check("req_addr", imem_req_addr, pcv);
        check("id_valid", 32'(id_valid), 32'(exp_idv));
        if (exp_idv) begin
            check("id_pc", id_pc, mf_pc[0]);
            check("id_instr", id_instr, mf_instr[0]);
        end
`ifdef IF_FETCH_STAGE_PERF_EN
        check("stall_cycles", stall_cycles, stall_exp);
`else
        check("stall_cycles", stall_cycles, 32'd0);
`endif
        @(posedge clk);
        rsp_push = 1'b0;
        rsp_addr = 32'h0;
        if (imem_rsp_valid) begin
            rsp_push = mem_live[0] && !redir;
            rsp_addr = mem_addr[0];
            void'(mem_addr.pop_front()); void'(mem_due.pop_front()); void'(mem_live.pop_front());
        end
        if (exp_idv && idr && !redir) begin
            void'(mf_pc.pop_front()); void'(mf_instr.pop_front());
        end
        if (rsp_push) begin
            mf_pc.push_back(rsp_addr);
            mf_instr.push_back(instr_of(rsp_addr));
        end
        if (redir) begin
            mf_pc.delete(); mf_instr.delete();
            foreach (mem_live[i]) mem_live[i] = 1'b0;
        end
        if (exp_adv) begin
            due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            mem_addr.push_back(pcv); mem_due.push_back(due); mem_live.push_back(1'b1);
            last_due = due;
        end
        if (idr && !exp_idv) stall_exp++;
        if (redir) pcv = redir_target;
        else if (exp_adv) pcv = pcv + 32'd4;
        cyc++;
        #1;
    endtask

    initial begin
        bit found;
        rst_n = 1'b0; pc = 32'h0; redirect = 1'b0; imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; id_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        model_reset(32'h0);

        // Streaming with single-cycle memory.
        rst_n = 1'b1;
        lat = 1; rdy = 1'b1; idr = 1'b1;
        repeat (20) do_cycle();
`ifdef IF_FETCH_STAGE_PERF_EN
        check("stream_starved", stall_exp, 32'd2);
`endif

        // Decode back-pressure, then drain.
        idr = 1'b0;
        repeat (10) do_cycle();
        idr = 1'b1;
        repeat (10) do_cycle();

        // Redirect with two requests outstanding.
        lat = 3;
        repeat (6) do_cycle();
        redir = 1'b1; redir_target = 32'h100;
        do_cycle();
        redir = 1'b0;
        repeat (12) do_cycle();

        // Redirect coinciding with a response while two are outstanding.
        lat = 2;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (mem_due.size() == 2 && mem_due[0] == cyc) found = 1'b1;
            else do_cycle();
        end
        check("coincide_setup", 32'(found), 32'd1);
        redir = 1'b1; redir_target = 32'h200;
        do_cycle();
        redir = 1'b0;
        repeat (10) do_cycle();

        // Memory refuses requests for five cycles.
        rdy = 1'b0;
        repeat (5) do_cycle();
        rdy = 1'b1;
        repeat (6) do_cycle();

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            rdy = ($urandom_range(0, 3) != 0);
            idr = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) lat = 1 + int'($urandom_range(0, 3));
            redir = ($urandom_range(0, 19) == 0);
            redir_target = $urandom & 32'hFFFF_FFFC;
            do_cycle();
        end
        redir = 1'b0;

        // Asynchronous reset mid-stream, then restart from a new PC.
        lat = 1; rdy = 1'b1; idr = 1'b1;
        repeat (8) do_cycle();
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        model_reset(32'h0000_4000);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cyc = 0;
        repeat (15) do_cycle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
        $fatal(1, "timeout");
    end

endmodule
